uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver. Successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, a valid/ready output handshake with a one-word holding register, and parity/framing/overrun error reporting.
- Sits between the board RX pin and the CPU-side UART peripheral registers.

Parameters:
- CLKS_PER_BIT, 1000: clk cycles per bit period; must be >= 4.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx  in  1  serial input, asynchronous to clk, idles high.
- re  in  1  receive enable; gates start-bit detection only.
- dout  out  DATA_BITS  received word; valid while valid=1.
- valid  out  1  word available; held until accepted.
- ready  in  1  consumer accepts; transfer occurs when valid && ready.
- parity_err  out  1  qualifier of dout; parity mismatch.
- frame_err  out  1  qualifier of dout; a stop bit was sampled low.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Synchroniser flops reset to 1.
- Input synchroniser: 2-flop; rx_s lags rx by 2 clk cycles. All decisions use rx_s.
- Counter: count is $clog2(CLKS_PER_BIT) bits wide; bit index is $clog2(DATA_BITS+1) bits wide.
- IDLE: if re && !rx_s -> START, with count=0.
- START:
  - At count == (CLKS_PER_BIT-1)/2, sample rx_s.
  - Low -> DATA with count=0. High (glitch) -> IDLE, nothing reported.
- DATA:
  - Sample at count == CLKS_PER_BIT-1 (mid-bit); shift in LSB-first.
  - After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY:
  - Sample one bit.
  - parity_calc = XOR of data bits, inverted for odd mode.
  - Mismatch sets the internal perr flag.
- STOP: sample STOP_BITS bits, one per bit period; any low sample sets the internal ferr flag.
- Word completion:
  - The cycle after the last stop sample: load the holding register, return to IDLE, re-arm immediately.
  - Line held low (break): data 0, frame_err=1, then waits in IDLE for rx_s high before a new start can be detected.
- Holding register / handshake:
  - On completion with valid=0 or (valid && ready) the same cycle: dout/parity_err/frame_err load, valid=1.
  - Completion with valid && !ready: new word dropped, overrun=1 for exactly one cycle, held word unchanged.
  - valid && ready with no completion: valid->0 next cycle; dout retains its value.
- Re-enable rules:
  - re deasserted mid-frame: the current frame completes and is delivered.
  - re affects only the IDLE->START transition.
- Latency: valid rises at stop-sample cycle + 1. That is about (1 + DATA_BITS + P + STOP_BITS - 0.5) bit periods + 2 sync cycles after the rx falling edge, where P = 1 if parity is enabled, else 0.
- Reset mid-frame: immediate return to IDLE; a partial word is never delivered.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every bit sample (start, data, parity, stop) is the majority of rx_s at sample point-1, point and point+1.
  - The sample is committed at point+1, so all later timing shifts by 1 cycle.
  - Requires CLKS_PER_BIT >= 8.
- Undefined: single sample at the sample point, as described above.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PARITY_NONE/ODD/EVEN.
  - State encoding IDLE/START/DATA/PARITY/STOP.
  - Shared with the future configurable transmitter.
- Sub-module uart_sync2: 2-flop synchroniser with reset value 1. Reusable for CTS and other async pins.

Test Plan:
- CLKS_PER_BIT=16, 8N1, ready=1: send 0xA5 -> valid pulses 1 cycle, dout=0xA5, no error flags.
- PARITY=2 (even), send 0x03 with parity bit 1 -> dout=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- STOP_BITS=2, second stop bit driven low, data 0x5A -> dout=0x5A, frame_err=1. Hold rx low for 3 frames (break) -> a single word 0x00 with frame_err=1, and no new word until rx returns high.
- ready=0, send 0x11 then 0x22 -> dout stays 0x11, valid stays high, overrun pulses once at the end of the 0x22 stop bit. ready=1 -> valid drops next cycle.
- rx low pulse of 4 cycles (< half bit), re=1 -> no valid, state back in IDLE. re=0 with a full frame -> no valid.
- Assert rst_n=0 during data bit 4 of 0xFF -> all outputs 0. Release, send 0x3C -> dout=0x3C, no stale bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver/transmitter state encoding
// and the 3-sample majority vote helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input pin.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with valid/ready holding register and error flags.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting (CLKS_PER_BIT >= 8).
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 re,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int HALF = (CLKS_PER_BIT - 1) / 2 + 1;
`else
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`endif
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic rx_s;
  logic bit_smp;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Committing one cycle late turns the held history into point-1 / point.
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_hist <= '1;
    else        rx_hist <= {rx_hist[0], rx_s};
  end

  assign bit_smp = maj3(rx_hist[1], rx_hist[0], rx_s);
`else
  assign bit_smp = rx_s;
`endif

  uart_state_e          state;
  logic [CW-1:0]        count;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 wait_high;
  logic                 parity_calc;

  assign parity_calc = (^shreg) ^ (PARITY == PARITY_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      wait_high  <= 1'b0;
      dout       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          count   <= '0;
          bit_idx <= '0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
          // After a break the line must go idle before another start is accepted.
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (re && !rx_s) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (count == HALF_CNT) begin
            count <= '0;
            state <= bit_smp ? ST_IDLE : ST_DATA;
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_DATA: begin
          if (count == LAST_CNT) begin
            count <= '0;
            shreg <= {bit_smp, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_PARITY: begin
          if (count == LAST_CNT) begin
            count <= '0;
            perr  <= (bit_smp != parity_calc);
            state <= ST_STOP;
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_STOP: begin
          if (count == LAST_CNT) begin
            count <= '0;
            if (bit_idx == LAST_STOP) begin
              state     <= ST_IDLE;
              wait_high <= !bit_smp;
              if (!valid || ready) begin
                dout       <= shreg;
                parity_err <= perr;
                frame_err  <= ferr | !bit_smp;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              ferr    <= ferr | !bit_smp;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
